// File: rtl/tpu_memory_loader_pkg.sv
// Shared types and geometry for the TPU operand-memory loader.
// Memory depth and address/count widths follow from the feature-map size.
package tpu_memory_loader_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int IMAGE_WIDTH  = 5;
    localparam int IMAGE_HEIGHT = 5;
    localparam int DEPTH        = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ADDR_W       = $clog2(DEPTH);
    localparam int CNT_W        = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        TGT_IMAGE  = 2'd0,
        TGT_KERNEL = 2'd1,
        TGT_BIAS   = 2'd2,
        TGT_RSVD   = 2'd3
    } mem_target_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } loader_state_e;

    // Widened by one bit so base+count cannot wrap before the bound check.
    function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                      input logic [CNT_W-1:0]  cnt);
        logic [CNT_W:0] sum;
        sum = (CNT_W+1)'(base) + (CNT_W+1)'(cnt);
        return sum <= (CNT_W+1)'(DEPTH);
    endfunction

endpackage

// File: rtl/tpu_memory_loader_if.sv
// Command, word-stream and memory-write bundle between a loader and its host/memories.
// slave = loader side, master = host/testbench side.
interface tpu_memory_loader_if import tpu_memory_loader_pkg::*; ();

    logic                  load_start;
    mem_target_e           load_target;
    logic [ADDR_W-1:0]     load_base;
    logic [CNT_W-1:0]      load_count;

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    logic                  wr_en_img;
    logic                  wr_en_ker;
    logic                  wr_en_bias;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport slave (
        input  load_start, load_target, load_base, load_count, s_valid, s_data,
        output s_ready, wr_en_img, wr_en_ker, wr_en_bias, wr_addr, wr_data
    );

    modport master (
        output load_start, load_target, load_base, load_count, s_valid, s_data,
        input  s_ready, wr_en_img, wr_en_ker, wr_en_bias, wr_addr, wr_data
    );

endinterface

// File: rtl/tpu_memory_loader.sv
// Streams FP16 words into the image/kernel/bias memory: one registered write the cycle after each accept,
// 1 word/cycle sustained; s_ready drops combinationally while tpu_busy is high.
module tpu_memory_loader import tpu_memory_loader_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    input  logic                tpu_busy,
    output logic                busy,
    output logic                load_done,
    output logic                cfg_error,
    tpu_memory_loader_if.slave  ld
);

    loader_state_e         state_q, state_d;
    mem_target_e           tgt_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [CNT_W-1:0]      rem_q;
    logic                  wr_vld_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  done_q;
    logic                  err_q;

    logic cmd_seen, cmd_bad, cmd_empty, cmd_go, accept, last_beat;

    assign cmd_seen  = (state_q == ST_IDLE) && ld.load_start;
    assign cmd_bad   = (ld.load_target == TGT_RSVD) || !range_ok(ld.load_base, ld.load_count);
    assign cmd_empty = (ld.load_count == '0);
    assign cmd_go    = cmd_seen && !cmd_bad && !cmd_empty;
    assign accept    = (state_q == ST_LOAD) && !tpu_busy && ld.s_valid;
    assign last_beat = accept && (rem_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_go)    state_d = ST_LOAD;
            ST_LOAD: if (last_beat) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == ST_LOAD);
        ld.s_ready    = (state_q == ST_LOAD) && !tpu_busy;
        ld.wr_en_img  = wr_vld_q && (tgt_q == TGT_IMAGE);
        ld.wr_en_ker  = wr_vld_q && (tgt_q == TGT_KERNEL);
        ld.wr_en_bias = wr_vld_q && (tgt_q == TGT_BIAS);
        ld.wr_addr    = wr_addr_q;
        ld.wr_data    = wr_data_q;
        load_done     = done_q;
        cfg_error     = err_q;
    end

    // Target stays latched after the last beat so the trailing write decodes correctly.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q     <= TGT_IMAGE;
            addr_q    <= '0;
            rem_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_vld_q <= accept;
            done_q   <= (cmd_seen && !cmd_bad && cmd_empty) || last_beat;
            err_q    <= cmd_seen && cmd_bad;
            if (cmd_go) begin
                tgt_q  <= ld.load_target;
                addr_q <= ld.load_base;
                rem_q  <= ld.load_count;
            end else if (accept) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - CNT_W'(1);
            end
            if (accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= ld.s_data;
            end
        end
    end

endmodule

// File: tb/tb_tpu_memory_loader.sv
// Directed bench for tpu_memory_loader: a negedge monitor logs writes into shadow memories,
// the main sequence drives commands/streams and compares against hand-computed values.
module tb_tpu_memory_loader;
    import tpu_memory_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tpu_busy;
    logic busy, load_done, cfg_error;

    tpu_memory_loader_if ifc();

    tpu_memory_loader dut (
        .clk       (clk),
        .reset     (reset),
        .tpu_busy  (tpu_busy),
        .busy      (busy),
        .load_done (load_done),
        .cfg_error (cfg_error),
        .ld        (ifc)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    int n_wr = 0, n_wr_img = 0, n_wr_ker = 0, n_wr_bias = 0;
    int n_done = 0, n_cerr = 0, n_stray = 0, n_multi = 0, n_order = 0, n_wr_busy = 0;
    int exp_addr = 0;
    logic acc_prev = 1'b0;
    logic [15:0] img_m  [0:DEPTH-1];
    logic [15:0] ker_m  [0:DEPTH-1];
    logic [15:0] bias_m [0:DEPTH-1];

    always @(negedge clk) begin
        int ones;
        int a;
        ones = int'(ifc.wr_en_img) + int'(ifc.wr_en_ker) + int'(ifc.wr_en_bias);
        a    = int'(ifc.wr_addr);
        if (ones > 1) n_multi++;
        if (ones > 0) begin
            n_wr++;
            if (tpu_busy) n_wr_busy++;
            if (a != exp_addr) n_order++;
            exp_addr = a + 1;
            if (a < DEPTH) begin
                if (ifc.wr_en_img)  begin img_m[a]  = ifc.wr_data; n_wr_img++;  end
                if (ifc.wr_en_ker)  begin ker_m[a]  = ifc.wr_data; n_wr_ker++;  end
                if (ifc.wr_en_bias) begin bias_m[a] = ifc.wr_data; n_wr_bias++; end
            end
        end
        if ((ones > 0) != acc_prev) n_stray++;
        if (load_done) n_done++;
        if (cfg_error) n_cerr++;
        acc_prev = ifc.s_valid && ifc.s_ready && !reset;
    end

    logic [15:0] src [$];
    int feed_cycles;
    int ready_low_cnt;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input mem_target_e t, input int base, input int cnt);
        ifc.load_start  = 1'b1;
        ifc.load_target = t;
        ifc.load_base   = ADDR_W'(base);
        ifc.load_count  = CNT_W'(cnt);
        step(1);
        ifc.load_start  = 1'b0;
    endtask

    // mode 0: valid held; 1: valid toggles 1-0-1; 2: tpu_busy in LOAD cycles 3-6; 3: stop after 10 accepts
    task automatic feed(input int mode, input int budget);
        int idx;
        int k;
        logic acc;
        idx = 0;
        k = 0;
        ready_low_cnt = 0;
        while (idx < src.size() && k < budget) begin
            k++;
            ifc.s_valid = (mode == 1) ? ((k % 2) == 1) : 1'b1;
            ifc.s_data  = src[idx];
            tpu_busy    = (mode == 2) && (k >= 3) && (k <= 6);
            @(negedge clk);
            if (tpu_busy && !ifc.s_ready) ready_low_cnt++;
            acc = ifc.s_valid && ifc.s_ready;
            step(1);
            if (acc) idx++;
            if (mode == 3 && idx == 10) break;
        end
        ifc.s_valid = 1'b0;
        tpu_busy    = 1'b0;
        feed_cycles = k;
        if (mode != 3 && idx < src.size()) chk("feed_timeout", idx, src.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, e0, b0, mm;
        int hot_idx [7];
        hot_idx = '{2, 3, 6, 8, 13, 17, 23};

        reset = 1'b1; tpu_busy = 1'b0;
        ifc.load_start = 1'b0; ifc.load_target = TGT_IMAGE;
        ifc.load_base = '0; ifc.load_count = '0;
        ifc.s_valid = 1'b0; ifc.s_data = '0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", ifc.s_ready, 0);
        chk("rst_wr_en", {ifc.wr_en_img, ifc.wr_en_ker, ifc.wr_en_bias}, 0);
        chk("rst_wr_addr", ifc.wr_addr, 0);
        chk("rst_wr_data", ifc.wr_data, 0);
        chk("rst_done_err", {load_done, cfg_error}, 0);
        reset = 1'b0;
        step(1);

        // 1: full 5x5 image, continuous stream
        src.delete();
        for (int i = 0; i < 25; i++) begin
            logic hot;
            hot = 1'b0;
            foreach (hot_idx[j]) if (hot_idx[j] == i) hot = 1'b1;
            src.push_back(hot ? 16'h3C00 : 16'h0000);
        end
        w0 = n_wr_img; exp_addr = 0;
        issue(TGT_IMAGE, 0, 25);
        chk("t1_busy", busy, 1);
        chk("t1_s_ready", ifc.s_ready, 1);
        feed(0, 200);
        chk("t1_cycles", feed_cycles, 25);
        chk("t1_done", load_done, 1);
        chk("t1_last_en", ifc.wr_en_img, 1);
        chk("t1_last_addr", ifc.wr_addr, 24);
        chk("t1_idle", {busy, ifc.s_ready}, 0);
        step(1);
        chk("t1_done_pulse", load_done, 0);
        chk("t1_nwr", n_wr_img - w0, 25);
        mm = 0;
        for (int i = 0; i < 25; i++) if (img_m[i] !== src[i]) mm++;
        chk("t1_readback", mm, 0);

        // 2: kernel with gappy valid
        src.delete();
        for (int r = 0; r < 3; r++) begin
            src.push_back(16'h3C00); src.push_back(16'h0000); src.push_back(16'hBC00);
        end
        w0 = n_wr_ker; exp_addr = 0;
        issue(TGT_KERNEL, 0, 9);
        feed(1, 200);
        chk("t2_cycles", feed_cycles, 17);
        chk("t2_done", load_done, 1);
        step(1);
        chk("t2_nwr", n_wr_ker - w0, 9);
        mm = 0;
        for (int i = 0; i < 9; i++) if (ker_m[i] !== src[i]) mm++;
        chk("t2_readback", mm, 0);
        chk("t2_stray", n_stray, 0);

        // 3: zero-length bias load
        d0 = n_done; w0 = n_wr;
        issue(TGT_BIAS, 3, 0);
        chk("t3_done", load_done, 1);
        chk("t3_busy", busy, 0);
        step(1);
        chk("t3_done_pulse", load_done, 0);
        chk("t3_nwr", n_wr - w0, 0);
        chk("t3_ndone", n_done - d0, 1);

        // 4: rejected commands, then the largest legal tail load
        e0 = n_cerr; w0 = n_wr;
        issue(TGT_IMAGE, 20, 9);
        chk("t4_err_range", cfg_error, 1);
        chk("t4_busy_range", busy, 0);
        step(1);
        chk("t4_err_pulse", cfg_error, 0);
        issue(TGT_RSVD, 0, 1);
        chk("t4_err_rsvd", cfg_error, 1);
        chk("t4_busy_rsvd", busy, 0);
        step(2);
        chk("t4_nerr", n_cerr - e0, 2);
        chk("t4_nwr", n_wr - w0, 0);
        src.delete();
        for (int i = 0; i < 9; i++) src.push_back(16'h1000 + 16'(i));
        exp_addr = 16;
        issue(TGT_IMAGE, 16, 9);
        chk("t4_edge_accept", {busy, cfg_error}, 2'b10);
        feed(0, 100);
        chk("t4_edge_last_addr", ifc.wr_addr, 24);
        step(1);
        chk("t4_edge_first", img_m[16], 16'h1000);
        chk("t4_edge_last", img_m[24], 16'h1008);

        // 5: tpu_busy stall in LOAD cycles 3-6
        src.delete();
        for (int i = 0; i < 9; i++) src.push_back(16'h2000 + 16'(i));
        w0 = n_wr_ker; b0 = n_wr_busy; exp_addr = 0;
        issue(TGT_KERNEL, 0, 9);
        feed(2, 200);
        chk("t5_cycles", feed_cycles, 13);
        step(1);
        chk("t5_ready_low", ready_low_cnt, 4);
        chk("t5_wr_in_busy", n_wr_busy - b0, 1);
        chk("t5_nwr", n_wr_ker - w0, 9);
        chk("t5_last_data", ker_m[8], 16'h2008);

        // 6: reset mid-load after 10 accepts, then a fresh command
        src.delete();
        for (int i = 0; i < 25; i++) src.push_back(16'h4000 + 16'(i));
        w0 = n_wr_img; exp_addr = 0;
        issue(TGT_IMAGE, 0, 25);
        feed(3, 200);
        chk("t6_accepts", feed_cycles, 10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_s_ready", ifc.s_ready, 0);
        chk("t6_wr_en", {ifc.wr_en_img, ifc.wr_en_ker, ifc.wr_en_bias}, 0);
        step(2);
        chk("t6_nwr", n_wr_img - w0, 10);
        src.delete();
        for (int i = 0; i < 3; i++) src.push_back(16'h5000 + 16'(i));
        w0 = n_wr_bias; exp_addr = 5;
        issue(TGT_BIAS, 5, 3);
        feed(0, 50);
        chk("t6_new_done", load_done, 1);
        step(1);
        chk("t6_new_nwr", n_wr_bias - w0, 3);
        chk("t6_new_data", bias_m[7], 16'h5002);

        chk("all_stray", n_stray, 0);
        chk("all_onehot", n_multi, 0);
        chk("all_order", n_order, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
